ffe_sample_sequencer: RTL and testbench

//  Sits directly upstream of the FFE datapath. Accepts one input sample per frame over a valid/ready handshake and holds the last DEPTH samples in a circular history buffer.
//  For each accepted sample it walks taps k=0..DEPTH-1 and drives rd_addr=k with rd_data=x[n-k].
//  It pulses str_out_n_rst_add_reg so the datapath dumps its accumulator as y and restarts.

---
 rtl/ffe_pkg.sv | 17 +
 rtl/ffe_hist_buf.sv | 33 +++
 rtl/ffe_sample_sequencer.sv | 136 +++++++++++++
 tb/tb_ffe_sample_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ffe_pkg.sv
// Shared definitions for the FFE sample sequencer: default sizes, FSM encoding
// and the tap-index width helper.
package ffe_pkg;

    localparam int IN_OUT_BUS_WIDTH_DEF = 12;
    localparam int DEPTH_DEF            = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int tap_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ffe_hist_buf.sv
// Circular sample history: DEPTH x IN_OUT_BUS_WIDTH register file with one
// write port, one combinational read port and asynchronous clear.
module ffe_hist_buf
    import ffe_pkg::*;
#(
    parameter int IN_OUT_BUS_WIDTH = IN_OUT_BUS_WIDTH_DEF,
    parameter int DEPTH            = DEPTH_DEF,
    parameter int ADDR_SIZE        = tap_width(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic        [ADDR_SIZE-1:0]        wr_ptr,
    input  logic signed [IN_OUT_BUS_WIDTH-1:0] wr_data,
    input  logic        [ADDR_SIZE-1:0]        rd_idx,
    output logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data
);

    logic signed [IN_OUT_BUS_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ffe_sample_sequencer.sv
// Feeds the FFE datapath one tap per cycle from a circular sample history.
// Define FFE_MULT_PIPE_EN to delay the store/clear strobe by one cycle.
module ffe_sample_sequencer
    import ffe_pkg::*;
#(
    parameter int IN_OUT_BUS_WIDTH = IN_OUT_BUS_WIDTH_DEF,
    parameter int DEPTH            = DEPTH_DEF,
    parameter int ADDR_SIZE        = tap_width(DEPTH)
) (
    input  logic                               ffe_clk,
    input  logic                               rst,
    input  logic signed [IN_OUT_BUS_WIDTH-1:0] x_in,
    input  logic                               x_in_valid,
    output logic                               x_in_ready,
    output logic        [ADDR_SIZE-1:0]        rd_addr,
    output logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data,
    output logic                               str_out_n_rst_add_reg,
    output logic                               y_valid
);

    localparam logic [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);

    state_t                             state, state_nxt;
    logic        [ADDR_SIZE-1:0]        k, k_nxt;
    logic        [ADDR_SIZE-1:0]        wr_ptr, wr_ptr_nxt, wr_ptr_inc;
    logic        [ADDR_SIZE-1:0]        wr_addr, rd_idx;
    logic        [ADDR_SIZE:0]          idx_wide;
    logic                               run, wr_en, strobe_now;
    logic signed [IN_OUT_BUS_WIDTH-1:0] hist_data;

    // A sample is taken when x_in_valid && x_in_ready on a rising ffe_clk; the
    // source must hold x_in stable while valid is high and ready is low.

    ffe_hist_buf #(
        .IN_OUT_BUS_WIDTH(IN_OUT_BUS_WIDTH),
        .DEPTH           (DEPTH),
        .ADDR_SIZE       (ADDR_SIZE)
    ) u_hist (
        .clk    (ffe_clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_ptr (wr_addr),
        .wr_data(x_in),
        .rd_idx (rd_idx),
        .rd_data(hist_data)
    );

    assign wr_ptr_inc = (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;

    // (wr_ptr - k) mod DEPTH without a power-of-two mask; one spare bit keeps
    // wr_ptr + DEPTH from overflowing for non-power-of-two depths.
    always_comb begin
        idx_wide = '0;
        if (wr_ptr >= k) begin
            idx_wide = {1'b0, wr_ptr} - {1'b0, k};
        end else begin
            idx_wide = {1'b0, wr_ptr} + (ADDR_SIZE + 1)'(DEPTH) - {1'b0, k};
        end
    end
    assign rd_idx = idx_wide[ADDR_SIZE-1:0];

    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            wr_ptr <= '0;
            run    <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            wr_ptr <= wr_ptr_nxt;
            run    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        wr_ptr_nxt = wr_ptr;
        wr_addr    = wr_ptr;
        wr_en      = 1'b0;
        strobe_now = 1'b0;
        x_in_ready = 1'b0;
        rd_addr    = '0;
        rd_data    = '0;
        case (state)
            IDLE: begin
                x_in_ready = run;
                if (x_in_valid && run) begin
                    wr_en     = 1'b1;
                    state_nxt = ISSUE;
                    k_nxt     = '0;
                end
            end
            ISSUE: begin
                rd_addr = k;
                rd_data = hist_data;
                if (k == LAST_TAP) begin
                    x_in_ready = 1'b1;
                    strobe_now = 1'b1;
                    wr_ptr_nxt = wr_ptr_inc;
                    // Back-to-back sample lands in the slot after the one just issued.
                    if (x_in_valid) begin
                        wr_en   = 1'b1;
                        wr_addr = wr_ptr_inc;
                        k_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FFE_MULT_PIPE_EN
    logic strobe_q;

    // Aligns with the datapath's registered multiplier output.
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_now;
        end
    end
    assign str_out_n_rst_add_reg = strobe_q;
`else
    assign str_out_n_rst_add_reg = strobe_now;
`endif

    assign y_valid = str_out_n_rst_add_reg;

endmodule

// File: tb/tb_ffe_sample_sequencer.sv
// Randomized scoreboard bench for ffe_sample_sequencer with a small FFE
// datapath model; honours FFE_MULT_PIPE_EN.
module tb_ffe_sample_sequencer;
    import ffe_pkg::*;

    localparam int W  = 12;
    localparam int D  = 4;
    localparam int A  = tap_width(D);
    localparam int SH = 11;

    logic                ffe_clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] x_in = '0;
    logic                x_in_valid = 1'b0;
    logic                x_in_ready;
    logic [A-1:0]        rd_addr;
    logic signed [W-1:0] rd_data;
    logic                str_out_n_rst_add_reg;
    logic                y_valid;

    int checks = 0;
    int errors = 0;

    logic [A+W-1:0]      exp_q[$];
    longint              exp_y_q[$];
    logic signed [W-1:0] hist_q[$];
    int                  h [D] = '{1024, -512, 320, -128};
    bit                  mon_en = 1'b0;
    bit                  pend = 1'b0;
    longint              acc = 0;
    longint              prod_q = 0;

    ffe_sample_sequencer dut (
        .ffe_clk              (ffe_clk),
        .rst                  (rst),
        .x_in                 (x_in),
        .x_in_valid           (x_in_valid),
        .x_in_ready           (x_in_ready),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .str_out_n_rst_add_reg(str_out_n_rst_add_reg),
        .y_valid              (y_valid)
    );

    always #5 ffe_clk = ~ffe_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame reads the newest D accepted samples, newest first,
    // zero where history does not reach; y is the FIR sum scaled by 2^-SH.
    task automatic model_accept(input logic signed [W-1:0] x);
        longint             y;
        logic signed [W-1:0] d;
        hist_q.push_front(x);
        if (hist_q.size() > D) void'(hist_q.pop_back());
        y = 0;
        for (int t = 0; t < D; t++) begin
            d = (t < hist_q.size()) ? hist_q[t] : '0;
            exp_q.push_back({A'(t), d});
            y += longint'(h[t]) * longint'(d);
        end
        exp_y_q.push_back(y >>> SH);
    endtask

    always @(negedge ffe_clk) begin : monitor
        logic [A-1:0]        ea;
        logic signed [W-1:0] ed;
        bit                  last, exp_rdy, exp_str;
        longint              p, y;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                {ea, ed} = exp_q.pop_front();
                last     = (ea == A'(D - 1));
                exp_rdy  = last;
            end else begin
                ea      = '0;
                ed      = '0;
                last    = 1'b0;
                exp_rdy = 1'b1;
            end
`ifdef FFE_MULT_PIPE_EN
            exp_str = pend;
            pend    = last;
`else
            exp_str = last;
`endif
            check("rd_addr", rd_addr, ea);
            check("rd_data", rd_data, ed);
            check("x_in_ready", x_in_ready, exp_rdy);
            check("strobe", str_out_n_rst_add_reg, exp_str);
            check("y_valid", y_valid, str_out_n_rst_add_reg);

            p = longint'(h[rd_addr]) * longint'(rd_data);
`ifdef FFE_MULT_PIPE_EN
            y      = acc + prod_q;
            prod_q = p;
`else
            y = acc + p;
`endif
            if (str_out_n_rst_add_reg) begin
                if (exp_y_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL y_unexpected: got strobe with y=%0d, expected no strobe", y >>> SH);
                end else begin
                    check("y", y >>> SH, exp_y_q.pop_front());
                end
                acc = 0;
            end else begin
                acc = y;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready", x_in_ready, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_strobe", str_out_n_rst_add_reg, 0);
        check("rst_y_valid", y_valid, 0);
    endtask

    // Called with rst high; returns at posedge+1 with monitoring enabled.
    task automatic release_reset();
        @(posedge ffe_clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_before_first_clk", x_in_ready, 0);
        @(posedge ffe_clk);
        #1;
        check("ready_after_first_clk", x_in_ready, 1);
        mon_en = 1'b1;
    endtask

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic signed [W-1:0] x, input int gap);
        int budget;
        bit got;
        x_in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge ffe_clk);
            #1;
        end
        x_in       = x;
        x_in_valid = 1'b1;
        budget     = 0;
        got        = 1'b0;
        while (!got && budget < 50) begin
            @(negedge ffe_clk);
            if (x_in_ready) got = 1'b1;
            else budget++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready stayed 0 for %0d cycles, expected 1", budget);
            @(posedge ffe_clk);
            #1;
            x_in_valid = 1'b0;
            return;
        end
        @(posedge ffe_clk);
        model_accept(x);
        #1;
        x_in_valid = 1'b0;
    endtask

    // Aborts a frame while tap k=2 is on the bus.
    task automatic reset_mid_frame(input logic signed [W-1:0] x);
        send(x, 1);
        @(posedge ffe_clk);
        @(posedge ffe_clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_y_q.delete();
        hist_q.delete();
        pend   = 1'b0;
        acc    = 0;
        prod_q = 0;
        release_reset();
    endtask

    initial begin
        #3;
        check_reset_outputs();
        release_reset();

        send(12'sd100, 0);
        reset_mid_frame(12'sd77);

        send(12'sd100, 0);
        send(12'sd200, 0);
        send(12'sd300, 0);

        for (int i = 1; i <= 5; i++) send(W'(i), 0);

        for (int i = 0; i < 4; i++) send(W'(-(i + 1) * 9), 2 + i);

        reset_mid_frame(-12'sd5);
        send(12'sd1000, 1);
        send(12'sd0, 2);

        for (int i = 0; i < 40; i++) begin
            send(W'($urandom_range(0, 4095)), $urandom_range(0, 3));
        end

        repeat (D + 4) @(posedge ffe_clk);
        #1;
        check("tap_queue_drained", exp_q.size(), 0);
        check("y_queue_drained", exp_y_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
